pll_supervisor: RTL and testbench

- Parametrised lock supervisor and reset sequencer that sits between an ECP5 EHXPLLL instance and the clock domains it feeds.
- Runs on the PLL reference clock, so it keeps running when the PLL outputs stop.
- Drives the PLL RST pin, debounces LOCK, and releases N_OUT per-domain resets in staggered order.
- Detects lock loss and timeouts, then automatically re-runs the PLL reset sequence and counts the events.

---
 rtl/pll_supervisor_if.sv | 25 ++
 rtl/pll_supervisor.sv | 169 ++++++++++++++++
 tb/tb_pll_supervisor.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_supervisor_if.sv
// Bundle between the PLL lock supervisor and its environment.
// The master side drives lock and restart inputs; the slave side is the supervisor.
interface pll_supervisor_if #(
    parameter int unsigned N_OUT = 2,
    parameter int unsigned CNT_W = 8
) ();
    logic             pll_locked;
    logic             force_restart;
    logic             pll_rst;
    logic [N_OUT-1:0] rst_out;
    logic             lock_ok;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] retry_cnt;
    logic [CNT_W-1:0] loss_cnt;

    modport master (
        output pll_locked, force_restart,
        input  pll_rst, rst_out, lock_ok, state_o, retry_cnt, loss_cnt
    );

    modport slave (
        input  pll_locked, force_restart,
        output pll_rst, rst_out, lock_ok, state_o, retry_cnt, loss_cnt
    );
endinterface

// File: rtl/pll_supervisor.sv
// ECP5 PLL lock supervisor: drives PLL RST, debounces LOCK, releases per-domain
// resets in staggered order, and restarts the PLL on timeout or lock loss.
module pll_supervisor #(
    parameter int unsigned N_OUT          = 2,
    parameter int unsigned RST_CYCLES     = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65535,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned STAGGER_CYCLES = 8,
    parameter int unsigned CNT_W          = 8
) (
    input  logic            clock,
    input  logic            reset,
    pll_supervisor_if.slave bus
);
    localparam int unsigned RST_W    = $clog2(RST_CYCLES) + 1;
    localparam int unsigned TO_W     = $clog2(LOCK_TIMEOUT) + 1;
    localparam int unsigned STB_W    = $clog2(STABLE_CYCLES) + 1;
    localparam int unsigned REL_W    = $clog2(N_OUT * STAGGER_CYCLES) + 1;
    localparam int unsigned REL_SPAN = (N_OUT - 1) * STAGGER_CYCLES;

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABILISE = 3'd2;
    localparam logic [2:0] S_RELEASE   = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;

    logic [2:0]       state_q,     state_d;
    logic             lk_meta_q,   lk_meta_d;
    logic             lk_q,        lk_d;
    logic [RST_W-1:0] rst_cnt_q,   rst_cnt_d;
    logic [TO_W-1:0]  to_cnt_q,    to_cnt_d;
    logic [STB_W-1:0] stb_cnt_q,   stb_cnt_d;
    logic [REL_W-1:0] rel_cnt_q,   rel_cnt_d;
    logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;
    logic [CNT_W-1:0] loss_cnt_q,  loss_cnt_d;
    logic             pll_rst_q,   pll_rst_d;
    logic [N_OUT-1:0] rst_out_q,   rst_out_d;
    logic             lock_ok_q,   lock_ok_d;
    logic             timeout_ev;
    logic             loss_ev;

    // Next-state, counters and registered-output decode.
    always_comb begin
        state_d    = state_q;
        lk_meta_d  = bus.pll_locked;
        lk_d       = lk_meta_q;
        rst_cnt_d  = '0;
        to_cnt_d   = '0;
        stb_cnt_d  = '0;
        rel_cnt_d  = '0;
        timeout_ev = 1'b0;
        loss_ev    = 1'b0;

        case (state_q)
            S_RESET_PLL: begin
                if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
                    state_d = S_WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (lk_q) begin
                    state_d  = S_STABILISE;
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end else if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
                    state_d    = S_RESET_PLL;
                    timeout_ev = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            // Glitches restart the stable count; the timeout keeps running from WAIT_LOCK entry.
            S_STABILISE: begin
                if (lk_q && (stb_cnt_q == STB_W'(STABLE_CYCLES - 1))) begin
                    state_d = S_RELEASE;
                end else if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
                    state_d    = S_RESET_PLL;
                    timeout_ev = 1'b1;
                end else begin
                    to_cnt_d  = to_cnt_q + TO_W'(1);
                    stb_cnt_d = lk_q ? (stb_cnt_q + STB_W'(1)) : '0;
                end
            end
            S_RELEASE: begin
                if (!lk_q) begin
                    state_d = S_RESET_PLL;
                    loss_ev = 1'b1;
                end else if (rel_cnt_q == REL_W'(REL_SPAN)) begin
                    state_d = S_RUN;
                end else begin
                    rel_cnt_d = rel_cnt_q + REL_W'(1);
                end
            end
            S_RUN: begin
                if (!lk_q) begin
                    state_d = S_RESET_PLL;
                    loss_ev = 1'b1;
                end
            end
            default: state_d = S_RESET_PLL;
        endcase

        // A forced restart overrides any same-cycle event and is never counted.
        if (bus.force_restart) begin
            state_d    = S_RESET_PLL;
            timeout_ev = 1'b0;
            loss_ev    = 1'b0;
            rst_cnt_d  = '0;
            to_cnt_d   = '0;
            stb_cnt_d  = '0;
            rel_cnt_d  = '0;
        end

        retry_cnt_d = (timeout_ev && (retry_cnt_q != '1)) ? (retry_cnt_q + CNT_W'(1)) : retry_cnt_q;
        loss_cnt_d  = (loss_ev && (loss_cnt_q != '1)) ? (loss_cnt_q + CNT_W'(1)) : loss_cnt_q;

        pll_rst_d = (state_d == S_RESET_PLL);
        lock_ok_d = (state_d == S_RUN);
        rst_out_d = '1;
        if (state_d == S_RUN) begin
            rst_out_d = '0;
        end else if (state_d == S_RELEASE) begin
            // Bit i drops once i*STAGGER_CYCLES cycles have elapsed since RELEASE entry.
            for (int unsigned i = 0; i < N_OUT; i++) begin
                if ((i * STAGGER_CYCLES) <= 32'(rel_cnt_d)) begin
                    rst_out_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_RESET_PLL;
            lk_meta_q   <= 1'b0;
            lk_q        <= 1'b0;
            rst_cnt_q   <= '0;
            to_cnt_q    <= '0;
            stb_cnt_q   <= '0;
            rel_cnt_q   <= '0;
            retry_cnt_q <= '0;
            loss_cnt_q  <= '0;
            pll_rst_q   <= 1'b1;
            rst_out_q   <= '1;
            lock_ok_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lk_meta_q   <= lk_meta_d;
            lk_q        <= lk_d;
            rst_cnt_q   <= rst_cnt_d;
            to_cnt_q    <= to_cnt_d;
            stb_cnt_q   <= stb_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
            pll_rst_q   <= pll_rst_d;
            rst_out_q   <= rst_out_d;
            lock_ok_q   <= lock_ok_d;
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.rst_out   = rst_out_q;
    assign bus.lock_ok   = lock_ok_q;
    assign bus.state_o   = state_q;
    assign bus.retry_cnt = retry_cnt_q;
    assign bus.loss_cnt  = loss_cnt_q;
endmodule

// File: tb/tb_pll_supervisor.sv
// Bench for pll_supervisor: two configurations checked every cycle against a
// timestamp-based reference model, plus directed scenarios with fixed expectations.
`timescale 1ns/1ps
module tb_pll_supervisor;
    localparam int A_N = 2, A_RST = 16, A_TO = 65535, A_STB = 1024, A_STG = 8, A_CW = 8;
    localparam int B_N = 4, B_RST = 16, B_TO = 100,   B_STB = 20,   B_STG = 3, B_CW = 2;

    localparam int PH_RESET = 0, PH_WAIT = 1, PH_STAB = 2, PH_REL = 3, PH_RUN = 4;
    localparam int C_PRST0 = 0, C_PRST1 = 1, C_STAB = 2, C_REL = 3, C_RUN = 4,
                   C_RO0 = 5, C_RO1 = 6, C_LOCK = 7, C_ALL1 = 8;

    typedef struct packed {
        int n_out; int rst_cycles; int timeout; int stable; int stagger; int cnt_max;
    } cfg_t;

    typedef struct packed {
        int phase; int t_phase; int t_wait; int run_len; int retry; int loss; int cyc;
        logic [1:0] hist;
    } model_t;

    localparam cfg_t CA = '{A_N, A_RST, A_TO, A_STB, A_STG, (1 << A_CW) - 1};
    localparam cfg_t CB = '{B_N, B_RST, B_TO, B_STB, B_STG, (1 << B_CW) - 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, frc_a = 1'b0, lck_a = 1'b0;
    logic rst_b = 1'b1, frc_b = 1'b0, lck_b = 1'b0;
    int   errors = 0;
    int   checks = 0;
    model_t ma = '0, mb = '0;
    bit   live_a = 1'b0, live_b = 1'b0;

    pll_supervisor_if #(.N_OUT(A_N), .CNT_W(A_CW)) bus_a ();
    pll_supervisor_if #(.N_OUT(B_N), .CNT_W(B_CW)) bus_b ();
    assign bus_a.pll_locked = lck_a;
    assign bus_a.force_restart = frc_a;
    assign bus_b.pll_locked = lck_b;
    assign bus_b.force_restart = frc_b;

    pll_supervisor #(.N_OUT(A_N), .RST_CYCLES(A_RST), .LOCK_TIMEOUT(A_TO), .STABLE_CYCLES(A_STB),
                     .STAGGER_CYCLES(A_STG), .CNT_W(A_CW))
        dut_a (.clock(clk), .reset(rst_a), .bus(bus_a));
    pll_supervisor #(.N_OUT(B_N), .RST_CYCLES(B_RST), .LOCK_TIMEOUT(B_TO), .STABLE_CYCLES(B_STB),
                     .STAGGER_CYCLES(B_STG), .CNT_W(B_CW))
        dut_b (.clock(clk), .reset(rst_b), .bus(bus_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic model_t enter(model_t m, int ph);
        m.phase   = ph;
        m.t_phase = m.cyc;
        return m;
    endfunction

    // One clock edge of the reference: elapsed times decide every transition.
    function automatic model_t step(model_t m, cfg_t c, logic rst, logic frc, logic raw);
        model_t r;
        int     age, waited;
        logic   lk;
        r     = m;
        r.cyc = m.cyc + 1;
        if (rst) begin
            r = enter(r, PH_RESET);
            r.t_wait = 0; r.run_len = 0; r.retry = 0; r.loss = 0; r.hist = 2'b00;
            return r;
        end
        lk     = m.hist[1];
        r.hist = {m.hist[0], raw};
        age    = m.cyc - m.t_phase;
        waited = m.cyc - m.t_wait + 1;
        if (frc) begin
            r = enter(r, PH_RESET);
        end else begin
            case (m.phase)
                PH_RESET: if (age + 1 >= c.rst_cycles) begin
                    r = enter(r, PH_WAIT);
                    r.t_wait = r.cyc;
                end
                PH_WAIT: if (lk) begin
                    r = enter(r, PH_STAB);
                    r.run_len = 0;
                end else if (waited >= c.timeout) begin
                    r.retry = (m.retry < c.cnt_max) ? m.retry + 1 : m.retry;
                    r = enter(r, PH_RESET);
                end
                PH_STAB: if (lk && m.run_len + 1 >= c.stable) begin
                    r = enter(r, PH_REL);
                end else if (waited >= c.timeout) begin
                    r.retry = (m.retry < c.cnt_max) ? m.retry + 1 : m.retry;
                    r = enter(r, PH_RESET);
                end else begin
                    r.run_len = lk ? m.run_len + 1 : 0;
                end
                default: if (!lk) begin
                    r.loss = (m.loss < c.cnt_max) ? m.loss + 1 : m.loss;
                    r = enter(r, PH_RESET);
                end else if (m.phase == PH_REL && age >= (c.n_out - 1) * c.stagger) begin
                    r = enter(r, PH_RUN);
                end
            endcase
        end
        return r;
    endfunction

    function automatic logic [28:0] expect_vec(model_t m, cfg_t c);
        logic [7:0] ro;
        int age;
        age = m.cyc - m.t_phase;
        ro  = '0;
        for (int i = 0; i < c.n_out; i++) begin
            if (m.phase == PH_REL)      ro[i] = (i * c.stagger > age);
            else if (m.phase == PH_RUN) ro[i] = 1'b0;
            else                        ro[i] = 1'b1;
        end
        return {m.phase == PH_RESET, m.phase == PH_RUN, 3'(m.phase), ro, 8'(m.retry), 8'(m.loss)};
    endfunction

    function automatic logic [28:0] act_a();
        return {bus_a.pll_rst, bus_a.lock_ok, bus_a.state_o, 8'(bus_a.rst_out),
                8'(bus_a.retry_cnt), 8'(bus_a.loss_cnt)};
    endfunction

    function automatic logic [28:0] act_b();
        return {bus_b.pll_rst, bus_b.lock_ok, bus_b.state_o, 8'(bus_b.rst_out),
                8'(bus_b.retry_cnt), 8'(bus_b.loss_cnt)};
    endfunction

    always @(posedge clk) begin
        ma = step(ma, CA, rst_a, frc_a, lck_a);
        mb = step(mb, CB, rst_b, frc_b, lck_b);
        if (rst_a) live_a = 1'b1;
        if (rst_b) live_b = 1'b1;
    end

    always @(negedge clk) begin
        if (live_a) chk("a_cycle", 32'(act_a()), 32'(expect_vec(ma, CA)));
        if (live_b) chk("b_cycle", 32'(act_b()), 32'(expect_vec(mb, CB)));
    end

    function automatic bit cond(int d, int sel);
        logic pr, lo;
        logic [2:0] st;
        logic [7:0] ro, all;
        if (d == 0) begin
            pr = bus_a.pll_rst; lo = bus_a.lock_ok; st = bus_a.state_o;
            ro = 8'(bus_a.rst_out); all = 8'h03;
        end else begin
            pr = bus_b.pll_rst; lo = bus_b.lock_ok; st = bus_b.state_o;
            ro = 8'(bus_b.rst_out); all = 8'h0F;
        end
        case (sel)
            C_PRST0: return !pr;
            C_PRST1: return pr;
            C_STAB:  return st == 3'd2;
            C_REL:   return st == 3'd3;
            C_RUN:   return st == 3'd4;
            C_RO0:   return !ro[0];
            C_RO1:   return !ro[1];
            C_LOCK:  return lo;
            C_ALL1:  return ro == all;
            default: return 1'b0;
        endcase
    endfunction

    // Counts falling edges until the condition holds; an expired bound fails.
    task automatic wait_for(input int d, input int sel, input int limit, input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cond(d, sel) && n < limit);
        chk({name, "_reached"}, 32'(cond(d, sel)), 32'd1);
    endtask

    task automatic run_a();
        int n, dly;
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        chk("a_reset_vals", 32'(act_a()), 32'({1'b1, 1'b0, 3'd0, 8'h03, 8'h00, 8'h00}));
        rst_a = 1'b0;
        wait_for(0, C_PRST0, 100, "a_prst", n);
        chk("a_prst_len", n, 16);
        repeat (34) @(negedge clk);
        lck_a = 1'b1;
        wait_for(0, C_STAB, 100, "a_stab", n);
        wait_for(0, C_RO0, 1200, "a_ro0", n);
        chk("a_stable_len", n, 1024);
        wait_for(0, C_RO1, 30, "a_ro1", n);
        chk("a_stagger", n, 8);
        wait_for(0, C_LOCK, 10, "a_lock", n);
        chk("a_run_lat", n, 1);
        chk("a_counters", {bus_a.retry_cnt, bus_a.loss_cnt}, 0);
        // single-cycle lock drop in RUN
        repeat (5) @(negedge clk);
        lck_a = 1'b0;
        @(negedge clk);
        lck_a = 1'b1;
        wait_for(0, C_ALL1, 10, "a_loss", n);
        chk("a_loss_lat", n + 1, 3);
        chk("a_loss_cnt", bus_a.loss_cnt, 1);
        chk("a_loss_state", {bus_a.state_o, bus_a.lock_ok}, 0);
        // glitch part-way through stabilise
        wait_for(0, C_STAB, 200, "a_stab2", n);
        repeat (500) @(negedge clk);
        lck_a = 1'b0;
        @(negedge clk);
        lck_a = 1'b1;
        wait_for(0, C_RO0, 1800, "a_ro0_glitch", n);
        n = n + 501;
        chk("a_glitch_delay", 32'(n >= 1524 && n <= 1530), 1);
        chk("a_glitch_retry", bus_a.retry_cnt, 0);
        wait_for(0, C_RUN, 50, "a_run2", n);
        // forced restart on the same cycle a loss is seen
        repeat (5) @(negedge clk);
        lck_a = 1'b0;
        @(negedge clk);
        lck_a = 1'b1;
        @(negedge clk);
        frc_a = 1'b1;
        @(negedge clk);
        frc_a = 1'b0;
        chk("a_force_state", {bus_a.pll_rst, bus_a.state_o, bus_a.rst_out}, {1'b1, 3'd0, 2'b11});
        chk("a_force_loss", bus_a.loss_cnt, 1);
        dly = 0;
        for (int c = 0; c < 12000; c++) begin
            @(negedge clk);
            frc_a = ($urandom_range(0, 1499) == 0);
            rst_a = ($urandom_range(0, 3999) == 0);
            if (bus_a.pll_rst) begin
                lck_a = 1'b0;
                dly = int'($urandom_range(0, 200));
            end else if (dly > 0) begin
                lck_a = 1'b0;
                dly--;
            end else begin
                lck_a = ($urandom_range(0, 2999) != 0);
            end
        end
        @(negedge clk);
        rst_a = 1'b0;
        frc_a = 1'b0;
    endtask

    task automatic run_b();
        int n, dly;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("b_reset_vals", 32'(act_b()), 32'({1'b1, 1'b0, 3'd0, 8'h0F, 8'h00, 8'h00}));
        rst_b = 1'b0;
        wait_for(1, C_PRST0, 50, "b_prst", n);
        chk("b_prst_len", n, 16);
        for (int i = 1; i <= 4; i++) begin
            wait_for(1, C_PRST1, 200, "b_timeout", n);
            chk("b_timeout_gap", n, 100);
            chk("b_retry", bus_b.retry_cnt, (i < 3) ? i : 3);
            wait_for(1, C_PRST0, 50, "b_prst_again", n);
            chk("b_prst_len_retry", n, 16);
        end
        lck_b = 1'b1;
        wait_for(1, C_REL, 100, "b_rel", n);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        chk("b_midrel_reset", 32'(act_b()), 32'({1'b1, 1'b0, 3'd0, 8'h0F, 8'h00, 8'h00}));
        rst_b = 1'b0;
        dly = 0;
        for (int c = 0; c < 12000; c++) begin
            @(negedge clk);
            frc_b = ($urandom_range(0, 699) == 0);
            rst_b = ($urandom_range(0, 2999) == 0);
            if (bus_b.pll_rst) begin
                lck_b = 1'b0;
                dly = int'($urandom_range(0, 130));
            end else if (dly > 0) begin
                lck_b = 1'b0;
                dly--;
            end else begin
                lck_b = ($urandom_range(0, 79) != 0);
            end
        end
        @(negedge clk);
        rst_b = 1'b0;
        frc_b = 1'b0;
    endtask

    initial begin
        fork
            run_a();
            run_b();
        join
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
